// File: rtl/fft16_pkg.sv
// Shared constants, FSM encoding and helpers for the 16-point FFT frame sequencer and core.
package fft16_pkg;
  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 32;

  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // W16^k = cos - j*sin, Q14, k = 0..7
  function automatic logic signed [15:0] tw_cos(input int k);
    case (k)
      0: return 16'sd16384;
      1: return 16'sd15137;
      2: return 16'sd11585;
      3: return 16'sd6270;
      4: return 16'sd0;
      5: return -16'sd6270;
      6: return -16'sd11585;
      default: return -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_sin(input int k);
    case (k)
      0: return 16'sd0;
      1: return 16'sd6270;
      2: return 16'sd11585;
      3: return 16'sd15137;
      4: return 16'sd16384;
      5: return 16'sd15137;
      6: return 16'sd11585;
      default: return 16'sd6270;
    endcase
  endfunction
endpackage

// File: rtl/fft16_frame_buf.sv
// 16-entry sample buffer: natural-order write index lands in the bit-reversed slot.
module fft16_frame_buf #(
  parameter int DW = fft16_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [DW-1:0]   data,
  output logic [16*DW-1:0] flat
);
  import fft16_pkg::*;

  logic [N-1:0][DW-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      mem <= '0;
    else if (clr) mem <= '0;
    else if (we)  mem[bitrev4(addr)] <= data;
  end

  assign flat = mem;
endmodule

// File: rtl/fft_stage_16.sv
// 16-point radix-2 DIT FFT core: bit-reversed real input, natural-order complex output.
module fft_stage_16 #(
  parameter int DW = fft16_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [16*DW-1:0] data_real_in_flat,
  output logic [16*DW-1:0] data_real_out_flat,
  output logic [16*DW-1:0] data_imag_out_flat,
  output logic             done
);
  import fft16_pkg::*;

  localparam int STAGES = LOG2N;

  logic [N-1:0][DW-1:0] y_re [STAGES];
  logic [N-1:0][DW-1:0] y_im [STAGES];
  logic [N-1:0][DW-1:0] r_re [STAGES];
  logic [N-1:0][DW-1:0] r_im [STAGES];
  logic [STAGES-1:0]    vld_pipe;
  logic [STAGES-1:0]    en;

  // One butterfly stage per pipeline register; stage s pairs elements H = 2^s apart.
  always_comb begin
    longint pr, pi;
    logic [DW-1:0] tr, ti, ar, ai;
    logic [LOG2N-1:0] lo, hi;
    int h, k;
    pr = 0; pi = 0; tr = '0; ti = '0; ar = '0; ai = '0; lo = '0; hi = '0; h = 1; k = 0;
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        y_re[s] = data_real_in_flat;
        y_im[s] = '0;
      end else begin
        y_re[s] = r_re[s-1];
        y_im[s] = r_im[s-1];
      end
      h = 1 << s;
      for (int i = 0; i < N; i++) begin
        if ((i & h) == 0) begin
          lo = LOG2N'(i);
          hi = LOG2N'(i + h);
          k  = (i & (h - 1)) << (STAGES - 1 - s);
          pr = longint'($signed(y_re[s][hi])) * longint'(tw_cos(k))
             + longint'($signed(y_im[s][hi])) * longint'(tw_sin(k)) + 64'sd8192;
          pi = longint'($signed(y_im[s][hi])) * longint'(tw_cos(k))
             - longint'($signed(y_re[s][hi])) * longint'(tw_sin(k)) + 64'sd8192;
          tr = DW'(pr >>> 14);
          ti = DW'(pi >>> 14);
          ar = y_re[s][lo];
          ai = y_im[s][lo];
          y_re[s][lo] = ar + tr;
          y_im[s][lo] = ai + ti;
          y_re[s][hi] = ar - tr;
          y_im[s][hi] = ai - ti;
        end
      end
    end
  end

  assign en = {vld_pipe[STAGES-2:0], ready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_re[s] <= '0;
        r_im[s] <= '0;
      end
    end else begin
      vld_pipe <= en;
      for (int s = 0; s < STAGES; s++) begin
        if (en[s]) begin
          r_re[s] <= y_re[s];
          r_im[s] <= y_im[s];
        end
      end
    end
  end

  assign data_real_out_flat = r_re[STAGES-1];
  assign data_imag_out_flat = r_im[STAGES-1];
  assign done               = vld_pipe[STAGES-1];
endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer: fill 16 samples, run fft_stage_16 under a watchdog, drain bins in order.
module fft16_frame_ctrl #(
  parameter int DW      = fft16_pkg::DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_real,
  output logic [DW-1:0] m_imag,
  output logic [3:0]    m_index,
  output logic          m_last,
  output logic          busy,
  output logic          err_timeout,
  output logic [15:0]   frame_cnt
);
  import fft16_pkg::*;

  state_t               state, state_nx;
  logic [LOG2N-1:0]     wr_cnt, rd_cnt;
  logic [15:0]          wd_cnt;
  logic                 wd_hit;
  logic                 core_ready, core_done;
  logic [16*DW-1:0]     in_flat;
  logic [N-1:0][DW-1:0] core_re, core_im;
  logic [N-1:0][DW-1:0] out_re, out_im;

  assign s_ready    = (state == S_FILL);
  assign busy       = (state != S_FILL);
  assign m_valid    = (state == S_DRAIN);
  assign core_ready = (state == S_START);
  assign m_real     = out_re[rd_cnt];
  assign m_imag     = out_im[rd_cnt];
  assign m_index    = rd_cnt;
  assign m_last     = m_valid && (rd_cnt == LOG2N'(N - 1));

  always_comb begin
    state_nx = state;
    wd_hit   = 1'b0;
    unique case (state)
      S_FILL:  if (s_valid && wr_cnt == LOG2N'(N - 1)) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        // done wins over a watchdog expiring in the same cycle
        if (core_done) state_nx = S_DRAIN;
        else if (wd_cnt == 16'(TIMEOUT - 1)) begin
          state_nx = S_FILL;
          wd_hit   = 1'b1;
        end
      end
      S_DRAIN: if (m_ready && rd_cnt == LOG2N'(N - 1)) state_nx = S_FILL;
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
      out_re      <= '0;
      out_im      <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FILL && s_valid) wr_cnt <= wr_cnt + 1'b1;
      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (state == S_WAIT && core_done) begin
        out_re <= core_re;
        out_im <= core_im;
      end else if (wd_hit) begin
        out_re      <= '0;
        out_im      <= '0;
        err_timeout <= 1'b1;
      end
      // counters wrap to 0 naturally after slot 15
      if (m_valid && m_ready) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LOG2N'(N - 1)) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  fft16_frame_buf #(.DW(DW)) u_in_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_hit),
    .we   (state == S_FILL && s_valid),
    .addr (wr_cnt),
    .data (s_data),
    .flat (in_flat)
  );

  fft_stage_16 #(.DW(DW)) u_core (
    .clk                (clk),
    .rst                (rst),
    .ready              (core_ready),
    .data_real_in_flat  (in_flat),
    .data_real_out_flat (core_re),
    .data_imag_out_flat (core_im),
    .done               (core_done)
  );
endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Scoreboard bench for fft16_frame_ctrl: directed frames, backpressure, watchdog and reset.
module tb_fft16_frame_ctrl;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0, rst = 1'b1;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_real, m_imag;
  logic [3:0]    m_index;
  logic          m_last, busy, err_timeout;
  logic [15:0]   frame_cnt;

  fft16_frame_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp, input longint tol = 0);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
  endtask

  typedef struct { longint re; longint im; int idx; longint tol; } exp_t;
  exp_t sb[$];
  int   pops = 0;

  task automatic push_bin(input int k, input longint re, input longint im, input longint tol);
    exp_t e;
    e.re = re; e.im = im; e.idx = k; e.tol = tol;
    sb.push_back(e);
  endtask

  // m_ready driver: level, or the 1,0,0,1 backpressure pattern
  bit bp_mode = 1'b0, mr_level = 1'b1;
  int bp_k = 0;
  always @(posedge clk) begin
    #2;
    if (bp_mode) begin
      m_ready = (bp_k % 4 == 0) || (bp_k % 4 == 3);
      bp_k++;
    end else m_ready = mr_level;
  end

  // monitor: pops the scoreboard on every handshake, checks stall stability
  bit            arm_lat = 1'b0, stalled = 1'b0;
  int            t_first = 0;
  logic [DW-1:0] hold_re, hold_im;
  logic [3:0]    hold_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst) stalled = 1'b0;
    else begin
      if (arm_lat && m_valid) begin
        chk("first_valid_latency", cyc - t_first, 21);
        arm_lat = 1'b0;
      end
      if (stalled && m_valid)
        chk("stall_stable", longint'(m_real == hold_re && m_imag == hold_im && m_index == hold_idx), 1);
      if (m_valid) chk("s_ready_in_drain", s_ready, 0);
      stalled = m_valid && !m_ready;
      hold_re = m_real; hold_im = m_imag; hold_idx = m_index;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("unexpected_bin", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk($sformatf("bin%0d_re", e.idx), $signed(m_real), e.re, e.tol);
          chk($sformatf("bin%0d_im", e.idx), $signed(m_imag), e.im, e.tol);
          chk($sformatf("bin%0d_index", e.idx), m_index, e.idx);
          chk($sformatf("bin%0d_last", e.idx), m_last, (e.idx == 15) ? 1 : 0);
          pops++;
        end
      end
    end
  end

  task automatic send_frame(input logic [DW-1:0] x [16]);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      chk("s_ready_fill", s_ready, 1);
      s_valid = 1'b1;
      s_data  = x[n];
      if (n == 0) t_first = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_drain(input longint exp_cnt);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("back_to_back_s_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // hand-computed 1000*W16^k, rounded
  longint br_re [16] = '{1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383, 0, 383, 707, 924};
  longint br_im [16] = '{0, -383, -707, -924, -1000, -924, -707, -383, 0, 383, 707, 924, 1000, 924, 707, 383};

  initial begin
    logic [DW-1:0] fr [16];
    int base, s_cyc;

    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_m_real", m_real, 0);
    chk("rst_m_index", m_index, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);

    // impulse at x[0]
    foreach (fr[i]) fr[i] = '0;
    fr[0] = 32'd1000;
    for (int k = 0; k < 16; k++) push_bin(k, 1000, 0, 0);
    arm_lat = 1'b1;
    send_frame(fr);
    wait_drain(1);

    // DC with backpressure
    bp_mode = 1'b1;
    foreach (fr[i]) fr[i] = 32'd100;
    push_bin(0, 1600, 0, 0);
    for (int k = 1; k < 16; k++) push_bin(k, 0, 0, 1);
    send_frame(fr);
    wait_drain(2);
    bp_mode = 1'b0;

    // impulse at x[1]: exercises the bit-reversed slot 8
    foreach (fr[i]) fr[i] = '0;
    fr[1] = 32'd1000;
    for (int k = 0; k < 16; k++) push_bin(k, br_re[k], br_im[k], (k % 4 == 0) ? 0 : 2);
    send_frame(fr);
    wait_drain(3);

    // watchdog: core done suppressed
    force dut.core_done = 1'b0;
    foreach (fr[i]) fr[i] = 32'd7;
    send_frame(fr);
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    s_cyc = cyc;
    for (int i = 0; i < 100 && !err_timeout; i++) @(negedge clk);
    chk("wd_err_set", err_timeout, 1);
    // start edge plus TIMEOUT further edges
    chk("wd_latency", cyc - s_cyc, TIMEOUT + 1);
    chk("wd_back_to_fill", busy, 0);
    chk("wd_no_m_valid", m_valid, 0);
    chk("wd_frame_cnt", frame_cnt, 3);
    release dut.core_done;

    // normal frame after timeout
    foreach (fr[i]) fr[i] = '0;
    fr[0] = -32'sd500;
    for (int k = 0; k < 16; k++) push_bin(k, -500, 0, 0);
    send_frame(fr);
    wait_drain(4);
    chk("err_sticky", err_timeout, 1);

    // reset mid-drain after bin 6
    foreach (fr[i]) fr[i] = '0;
    fr[0] = 32'd1000;
    for (int k = 0; k < 16; k++) push_bin(k, 1000, 0, 0);
    base = pops;
    send_frame(fr);
    for (int i = 0; i < 200 && pops < base + 7; i++) @(negedge clk);
    chk("bins_before_reset", pops - base, 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_async_m_valid", m_valid, 0);
    chk("rst_async_frame_cnt", frame_cnt, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_err", err_timeout, 0);
    chk("rst_async_m_real", m_real, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_mid_rst", s_ready, 1);
    chk("m_valid_after_mid_rst", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
